arith_sequencer: RTL

Accumulator-style controller that sequences the shared 16-bit arithmetic unit (opcodes: add, sign-magnitude multiply, subtract V2−V1) for the calculator front-end. It accepts LOAD/APPLY/CLEAR commands over a valid/ready handshake and holds the running result in an accumulator. For each APPLY it presents operands and opcode to the unit with a one-cycle `newop` strobe, waits the unit's fixed latency, and captures `answer` back into the accumulator with add/subtract overflow detection.

---
 rtl/arith_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/arith_sequencer.sv
// Accumulator controller that sequences a shared fixed-latency arithmetic unit.
// Accepts LOAD/APPLY/CLEAR commands and writes APPLY results back into the accumulator.
module arith_sequencer #(
    parameter int WIDTH     = 16,
    parameter int ARITH_LAT = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_code,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_value,
    output logic [WIDTH-1:0] arith_V1,
    output logic [WIDTH-1:0] arith_V2,
    output logic [1:0]       arith_opcode,
    output logic             arith_newop,
    input  logic [WIDTH-1:0] arith_answer,
    output logic [WIDTH-1:0] acc,
    output logic             acc_valid,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_APPLY = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;
    localparam int         MSB       = WIDTH - 1;

    // WAIT runs for WAIT_INIT+1 cycles, i.e. ARITH_LAT-1; unused when ARITH_LAT is 1.
    localparam logic [3:0] WAIT_INIT = (ARITH_LAT >= 2) ? 4'(ARITH_LAT - 2) : 4'd0;
    localparam bit         SKIP_WAIT = (ARITH_LAT == 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       apply_go;
    logic       add_ovf;
    logic       sub_ovf;

    assign accept   = cmd_valid & cmd_ready;
    assign apply_go = accept && (cmd_code == CMD_APPLY) && (cmd_op != OP_ILL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (apply_go) state_nxt = ISSUE;
            ISSUE:   state_nxt = SKIP_WAIT ? CAPTURE : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        arith_newop = 1'b0;
        case (state)
            IDLE:    cmd_ready   = 1'b1;
            ISSUE:   arith_newop = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (state == ISSUE) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Signed overflow judged from operand/result sign bits; subtract is V2 - V1.
    assign add_ovf = (arith_V1[MSB] == arith_V2[MSB]) && (arith_answer[MSB] != arith_V1[MSB]);
    assign sub_ovf = (arith_V1[MSB] != arith_V2[MSB]) && (arith_answer[MSB] != arith_V2[MSB]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arith_V1     <= '0;
            arith_V2     <= '0;
            arith_opcode <= 2'b00;
            acc          <= '0;
            acc_valid    <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_code)
                            CMD_LOAD: begin
                                acc       <= cmd_value;
                                acc_valid <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                acc       <= '0;
                                acc_valid <= 1'b0;
                                ovf       <= 1'b0;
                                err       <= 1'b0;
                            end
                            CMD_APPLY: begin
                                if (cmd_op == OP_ILL) begin
                                    err <= 1'b1;
                                end else begin
                                    arith_V1     <= cmd_value;
                                    arith_V2     <= acc_valid ? acc : '0;
                                    arith_opcode <= cmd_op;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CAPTURE: begin
                    acc       <= arith_answer;
                    acc_valid <= 1'b1;
                    done      <= 1'b1;
                    case (arith_opcode)
                        OP_ADD:  ovf <= add_ovf;
                        OP_SUB:  ovf <= sub_ovf;
                        default: ovf <= 1'b0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
